weight_dma_loader: RTL

Moves one layer's weights from DRAM into the GLB before `weight_load_state_i` is raised on the token-engine weight loader. It issues single-outstanding burst reads on the DRAM read channel and buffers beats in a small FIFO. It writes packed 32-bit words to the GLB weight region starting at the GLB weight base address, then pulses done. The weight loader later reads those bytes one at a time.

---
 rtl/weight_dma_loader_pkg.sv | 41 ++++
 rtl/weight_dma_loader_fifo.sv | 46 ++++
 rtl/weight_dma_loader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/weight_dma_loader_pkg.sv
// Shared definitions for the weight DMA path: layer-type encodings, FSM states
// and per-layer-type weight sizes (also used by the weight load controller).
package weight_dma_loader_pkg;

  typedef enum logic [1:0] {
    POINTWISE = 2'd0,
    DEPTHWISE = 2'd1,
    STANDARD  = 2'd2,
    LINEAR    = 2'd3
  } layer_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_DRAIN,
    S_DONE
  } dma_state_e;

  function automatic logic [31:0] layer_bytes(input logic [1:0] lt);
    logic [31:0] bytes;
    case (layer_type_e'(lt))
      POINTWISE: bytes = 32'd1024;
      DEPTHWISE: bytes = 32'd90;
      STANDARD:  bytes = 32'd900;
      LINEAR:    bytes = 32'd1024;
      default:   bytes = 32'd1024;
    endcase
    return bytes;
  endfunction

  function automatic logic [31:0] layer_words(input logic [1:0] lt);
    return (layer_bytes(lt) + 32'd3) >> 2;
  endfunction

  // High when the last word carries only its two low bytes.
  function automatic logic layer_tail_half(input logic [1:0] lt);
    return (layer_bytes(lt) % 32'd4) == 32'd2;
  endfunction

endpackage

// File: rtl/weight_dma_loader_fifo.sv
// Small synchronous FIFO for DRAM beats; storage is registered and the head
// entry is presented directly, so a push is visible to the reader next cycle.
module weight_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push && !full) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr <= wptr + PTR_ONE;
      end
      if (pop && !empty) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/weight_dma_loader.sv
// Copies one layer's weights from DRAM into the GLB weight region using
// single-outstanding burst reads buffered through a small FIFO.
module weight_dma_loader
  import weight_dma_loader_pkg::*;
#(
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic [1:0]                   layer_type_i,
  input  logic [31:0]                  dram_base_addr_i,
  input  logic [31:0]                  glb_base_addr_i,
  output logic                         dram_rd_req_o,
  output logic [31:0]                  dram_rd_addr_o,
  output logic [$clog2(MAX_BURST):0]   dram_rd_len_o,
  input  logic                         dram_rd_gnt_i,
  input  logic                         dram_rd_valid_i,
  input  logic [31:0]                  dram_rd_data_i,
  input  logic                         dram_rd_last_i,
  output logic                         dram_rd_ready_o,
  output logic                         glb_we_o,
  output logic [31:0]                  glb_waddr_o,
  output logic [31:0]                  glb_wdata_o,
  output logic [3:0]                   glb_wstrb_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int unsigned LW = $clog2(MAX_BURST) + 1;

  dma_state_e state, state_nxt;

  logic [31:0]   dram_base_q;
  logic [31:0]   glb_base_q;
  logic [31:0]   total_q;
  logic          tail_half_q;
  logic [31:0]   words_req_q;
  logic [31:0]   beats_left_q;
  logic [31:0]   words_wr_q;
  logic          err_q;

  logic [31:0]   remain;
  logic [LW-1:0] burst_len;
  logic          fifo_full;
  logic          fifo_empty;
  logic [31:0]   fifo_rdata;
  logic          beat_acc;
  logic          glb_we;
  logic          final_beat;
  logic [31:0]   words_wr_nxt;

  assign remain       = total_q - words_req_q;
  assign burst_len    = (remain > 32'(MAX_BURST)) ? LW'(MAX_BURST) : remain[LW-1:0];
  assign beat_acc     = (state == S_DATA) && !fifo_full && dram_rd_valid_i;
  assign glb_we       = (state != S_IDLE) && !fifo_empty;
  assign final_beat   = (beats_left_q == 32'd1);
  assign words_wr_nxt = words_wr_q + {31'd0, glb_we};

  weight_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (beat_acc),
    .wdata (dram_rd_data_i),
    .pop   (glb_we),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    dram_rd_req_o   = 1'b0;
    dram_rd_addr_o  = '0;
    dram_rd_len_o   = '0;
    dram_rd_ready_o = 1'b0;
    busy_o          = (state != S_IDLE);
    done_o          = 1'b0;
    err_o           = err_q;
    glb_we_o        = glb_we;
    glb_waddr_o     = '0;
    glb_wdata_o     = '0;
    glb_wstrb_o     = '0;

    if (glb_we) begin
      glb_waddr_o = glb_base_q + (words_wr_q << 2);
      glb_wdata_o = fifo_rdata;
      glb_wstrb_o = (tail_half_q && (words_wr_q == total_q - 32'd1)) ? 4'b0011 : 4'b1111;
    end

    case (state)
      S_IDLE: begin
        if (start_i) state_nxt = S_REQ;
      end
      S_REQ: begin
        dram_rd_req_o  = 1'b1;
        dram_rd_addr_o = dram_base_q + (words_req_q << 2);
        dram_rd_len_o  = burst_len;
        if (dram_rd_gnt_i) state_nxt = S_DATA;
      end
      S_DATA: begin
        dram_rd_ready_o = !fifo_full;
        if (beat_acc && final_beat) begin
          state_nxt = (words_req_q == total_q) ? S_DRAIN : S_REQ;
        end
      end
      S_DRAIN: begin
        // Leave on the cycle of the final write so done follows it directly;
        // every requested beat is already in the FIFO, so this also means empty.
        if (words_wr_nxt == total_q) state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dram_base_q  <= '0;
      glb_base_q   <= '0;
      total_q      <= '0;
      tail_half_q  <= 1'b0;
      words_req_q  <= '0;
      beats_left_q <= '0;
      words_wr_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start_i) begin
        dram_base_q  <= {dram_base_addr_i[31:2], 2'b00};
        glb_base_q   <= {glb_base_addr_i[31:2], 2'b00};
        total_q      <= layer_words(layer_type_i);
        tail_half_q  <= layer_tail_half(layer_type_i);
        words_req_q  <= '0;
        beats_left_q <= '0;
        words_wr_q   <= '0;
        err_q        <= 1'b0;
      end
      if ((state == S_REQ) && dram_rd_gnt_i) begin
        words_req_q  <= words_req_q + 32'(burst_len);
        beats_left_q <= 32'(burst_len);
      end
      if (beat_acc) begin
        beats_left_q <= beats_left_q - 32'd1;
        if (dram_rd_last_i != final_beat) err_q <= 1'b1;
      end
      if (glb_we) begin
        words_wr_q <= words_wr_q + 32'd1;
      end
    end
  end

endmodule
